// File: rtl/program_encoder.sv
// Packs field-level RV32I instruction descriptions into words and writes them to sequential instruction-memory addresses.
// Latency: fields accepted at edge T are presented with mem_we high during T..T+1 and captured at edge T+1; at most 1 word per 2 cycles.
// Backpressure: in_ready is low while a write is pending, while the memory is full, and during clear or reset.
module program_encoder #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned BASE_ADDR  = 0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2:0]            fmt,
  input  logic [2:0]            funct3,
  input  logic                  alt,
  input  logic [4:0]            rd,
  input  logic [4:0]            rs1,
  input  logic [4:0]            rs2,
  input  logic [31:0]           imm,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  full,
  output logic                  error
);

  // Field-format codes as presented on fmt.
  localparam logic [2:0] FMT_R     = 3'd0;
  localparam logic [2:0] FMT_IALU  = 3'd1;
  localparam logic [2:0] FMT_SHIFT = 3'd2;
  localparam logic [2:0] FMT_LOAD  = 3'd3;
  localparam logic [2:0] FMT_STORE = 3'd4;

  // RV32I major opcodes.
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;

  localparam logic [ADDR_WIDTH-1:0] BASE     = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [ADDR_WIDTH:0]   CAPACITY = {1'b1, {ADDR_WIDTH{1'b0}}};

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } state_t;

  state_t                  state_q;
  state_t                  state_d;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [31:0]             wdata_q;
  logic [ADDR_WIDTH:0]     count_q;
  logic                    error_q;

  logic                    accept;
  logic                    imm_fits12;
  logic                    shamt_ok;
  logic                    enc_legal;
  logic [31:0]             enc_word;

  // A 12-bit signed immediate fits when bits 31..11 are all copies of the sign.
  assign imm_fits12 = (imm[31:11] == {21{imm[11]}});
  // Shift amounts are 5-bit unsigned and only SLLI/SRLI/SRAI funct3 codes exist.
  assign shamt_ok   = (imm[31:5] == 27'd0) && ((funct3 == 3'b001) || (funct3 == 3'b101));

  assign full      = (count_q == CAPACITY);
  assign in_ready  = (state_q == IDLE) && !full && !clear && !reset;
  assign accept    = in_valid && in_ready;

  assign mem_we    = (state_q == WRITE);
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign count     = count_q;
  assign error     = error_q;

  // Encode the presented fields and decide whether the description is legal.
  always_comb begin
    enc_word  = 32'd0;
    enc_legal = 1'b0;
    unique case (fmt)
      FMT_R: begin
        enc_word  = {1'b0, alt, 5'b00000, rs2, rs1, funct3, rd, OP_REG};
        enc_legal = 1'b1;
      end
      FMT_IALU: begin
        enc_word  = {imm[11:0], rs1, funct3, rd, OP_IMM};
        enc_legal = imm_fits12;
      end
      FMT_SHIFT: begin
        enc_word  = {1'b0, alt, 5'b00000, imm[4:0], rs1, funct3, rd, OP_IMM};
        enc_legal = shamt_ok;
      end
      FMT_LOAD: begin
        enc_word  = {imm[11:0], rs1, funct3, rd, OP_LOAD};
        enc_legal = imm_fits12;
      end
      FMT_STORE: begin
        enc_word  = {imm[11:5], rs2, rs1, funct3, imm[4:0], OP_STORE};
        enc_legal = imm_fits12;
      end
      default: begin
        enc_word  = 32'd0;
        enc_legal = 1'b0;
      end
    endcase
  end

  // Next-state logic: a legal accept starts a one-cycle write, which always returns to IDLE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept && enc_legal) state_d = WRITE;
      WRITE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath: latch the encoded word, advance address/count after each write, honour clear.
  always_ff @(posedge clock) begin
    if (reset) begin
      addr_q  <= BASE;
      wdata_q <= 32'd0;
      count_q <= '0;
      error_q <= 1'b0;
    end else begin
      error_q <= accept && !enc_legal;
      if (accept && enc_legal) begin
        wdata_q <= enc_word;
      end
      // Clear beats the post-write increment; the write itself still happened this cycle.
      if (clear) begin
        addr_q  <= BASE;
        count_q <= '0;
      end else if (state_q == WRITE) begin
        addr_q  <= addr_q + ADDR_WIDTH'(1);
        count_q <= count_q + (ADDR_WIDTH + 1)'(1);
      end
    end
  end

endmodule

// File: tb/tb_program_encoder.sv
module tb_program_encoder;

  localparam int AW   = 2;
  localparam int BASE = 3;
  localparam int CAP  = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          clear = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [2:0]    fmt = 3'd0;
  logic [2:0]    funct3 = 3'd0;
  logic          alt = 1'b0;
  logic [4:0]    rd = 5'd0;
  logic [4:0]    rs1 = 5'd0;
  logic [4:0]    rs2 = 5'd0;
  logic [31:0]   imm = 32'd0;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [AW:0]   count;
  logic          full;
  logic          error;

  int total = 0;
  int bad   = 0;
  int exp_count = 0;

  program_encoder #(.ADDR_WIDTH(AW), .BASE_ADDR(BASE)) dut (
    .clock(clock), .reset(reset), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready),
    .fmt(fmt), .funct3(funct3), .alt(alt),
    .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .count(count), .full(full), .error(error)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int exp_addr();
    return (BASE + exp_count) % CAP;
  endfunction

  // Reference encoder built from field positions with plain arithmetic.
  function automatic longint ref_enc(input longint f, input longint f3, input longint a,
                                     input longint rdv, input longint rs1v, input longint rs2v,
                                     input longint immv, output bit ok);
    longint w;
    longint u;
    w  = 0;
    ok = 1'b0;
    u  = (immv + 4096) % 4096;
    case (f)
      0: begin
        ok = 1'b1;
        w  = 'h33 + rdv * 128 + f3 * 4096 + rs1v * 32768 + rs2v * 1048576 + a * 1073741824;
      end
      1, 3: begin
        ok = (immv >= -2048) && (immv <= 2047);
        w  = ((f == 1) ? 'h13 : 'h03) + rdv * 128 + f3 * 4096 + rs1v * 32768 + u * 1048576;
      end
      2: begin
        ok = (immv >= 0) && (immv < 32) && (f3 == 1 || f3 == 5);
        w  = 'h13 + rdv * 128 + f3 * 4096 + rs1v * 32768 + immv * 1048576 + a * 1073741824;
      end
      4: begin
        ok = (immv >= -2048) && (immv <= 2047);
        w  = 'h23 + (u % 32) * 128 + f3 * 4096 + rs1v * 32768 + rs2v * 1048576 + (u / 32) * 33554432;
      end
      default: ok = 1'b0;
    endcase
    return w % 64'h1_0000_0000;
  endfunction

  // Present one description (called in the drive phase, after a negedge).
  // mode 0: normal, 1: clear during the write cycle, 2: reset during the write cycle.
  task automatic do_op(input int f, input int f3, input int a, input int rdv, input int rs1v,
                       input int rs2v, input int immv, input bit hold, input int mode);
    longint w;
    bit ok;
    int n;
    w = ref_enc(f, f3, a, rdv, rs1v, rs2v, immv, ok);
    fmt = 3'(f); funct3 = 3'(f3); alt = 1'(a);
    rd = 5'(rdv); rs1 = 5'(rs1v); rs2 = 5'(rs2v); imm = immv;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clock);
      n++;
    end
    chk("ready_wait", {31'd0, in_ready}, 32'd1);
    @(posedge clock);
    #1;
    if (!hold || !ok) in_valid = 1'b0;
    if (ok) begin
      chk("we_write", {31'd0, mem_we}, 32'd1);
      chk("addr_write", {30'd0, mem_addr}, exp_addr());
      chk("wdata", mem_wdata, w[31:0]);
      chk("ready_in_write", {31'd0, in_ready}, 32'd0);
      chk("no_err_legal", {31'd0, error}, 32'd0);
      if (mode == 1) clear = 1'b1;
      if (mode == 2) reset = 1'b1;
      @(posedge clock);
      #1;
      if (mode == 0) exp_count++;
      else exp_count = 0;
      chk("we_after", {31'd0, mem_we}, 32'd0);
      chk("count_after", {29'd0, count}, exp_count);
      chk("addr_after", {30'd0, mem_addr}, exp_addr());
      chk("full_after", {31'd0, full}, {31'd0, exp_count == CAP});
      if (mode == 2) begin
        chk("rst_wdata", mem_wdata, 32'd0);
        chk("rst_err", {31'd0, error}, 32'd0);
        chk("rst_ready", {31'd0, in_ready}, 32'd0);
      end
      clear = 1'b0;
      reset = 1'b0;
    end else begin
      chk("err_pulse", {31'd0, error}, 32'd1);
      chk("we_reject", {31'd0, mem_we}, 32'd0);
      chk("count_reject", {29'd0, count}, exp_count);
      @(posedge clock);
      #1;
      chk("err_gone", {31'd0, error}, 32'd0);
      chk("we_reject2", {31'd0, mem_we}, 32'd0);
    end
    @(negedge clock);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    #1;
    chk("ready_in_clear", {31'd0, in_ready}, 32'd0);
    @(posedge clock);
    #1;
    clear = 1'b0;
    exp_count = 0;
    chk("clear_count", {29'd0, count}, 32'd0);
    chk("clear_addr", {30'd0, mem_addr}, exp_addr());
    chk("clear_full", {31'd0, full}, 32'd0);
    @(negedge clock);
  endtask

  initial begin
    int f, f3, immv, sel;
    // Reset state.
    repeat (2) @(posedge clock);
    #1;
    chk("rst_we", {31'd0, mem_we}, 32'd0);
    chk("rst_addr", {30'd0, mem_addr}, BASE);
    chk("rst_wdata0", mem_wdata, 32'd0);
    chk("rst_count", {29'd0, count}, 32'd0);
    chk("rst_full", {31'd0, full}, 32'd0);
    chk("rst_error", {31'd0, error}, 32'd0);
    chk("rst_ready0", {31'd0, in_ready}, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk("ready_idle", {31'd0, in_ready}, 32'd1);

    // Directed encodings, including a back-to-back pair with in_valid held.
    do_op(1, 0, 0, 1, 0, 0, 5, 1'b0, 0);
    do_op(0, 0, 1, 3, 1, 2, 0, 1'b1, 0);
    do_op(2, 5, 1, 5, 6, 0, 3, 1'b0, 0);
    do_op(4, 2, 0, 0, 1, 2, 8, 1'b0, 0);

    // Memory is full: further requests are ignored.
    chk("full_set", {31'd0, full}, 32'd1);
    chk("full_ready", {31'd0, in_ready}, 32'd0);
    in_valid = 1'b1;
    repeat (3) begin
      @(posedge clock);
      #1;
      chk("full_no_we", {31'd0, mem_we}, 32'd0);
      chk("full_count", {29'd0, count}, CAP);
      chk("full_no_err", {31'd0, error}, 32'd0);
    end
    in_valid = 1'b0;
    @(negedge clock);
    do_clear();
    do_op(3, 2, 0, 4, 1, 0, -4, 1'b0, 0);

    // Rejected descriptions.
    do_op(1, 0, 0, 1, 0, 0, 2048, 1'b0, 0);
    do_op(2, 1, 0, 1, 0, 0, 32, 1'b0, 0);
    do_op(6, 0, 0, 1, 0, 0, 0, 1'b0, 0);
    do_op(4, 2, 0, 0, 1, 2, -2049, 1'b0, 0);

    // Clear during a write, then reset during a write.
    do_op(0, 7, 0, 9, 10, 11, 0, 1'b0, 1);
    do_op(1, 4, 0, 2, 3, 0, -2048, 1'b0, 2);

    // Randomized descriptions against the reference encoder.
    for (int i = 0; i < 40; i++) begin
      if (exp_count == CAP) do_clear();
      f   = $urandom_range(0, 7);
      f3  = $urandom_range(0, 7);
      if (f == 2 && $urandom_range(0, 1) == 1) f3 = ($urandom_range(0, 1) == 1) ? 5 : 1;
      sel = $urandom_range(0, 3);
      case (sel)
        0: immv = $urandom_range(0, 80) - 40;
        1: begin
          case ($urandom_range(0, 3))
            0: immv = -2048;
            1: immv = 2047;
            2: immv = 2048;
            default: immv = -2049;
          endcase
        end
        2: immv = $urandom_range(0, 40);
        default: immv = int'($urandom);
      endcase
      do_op(f, f3, $urandom_range(0, 1), $urandom_range(0, 31), $urandom_range(0, 31),
            $urandom_range(0, 31), immv, 1'($urandom_range(0, 1)), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
